multicycle_ctrl_unit: RTL

Multi-cycle control FSM for the Nios II-subset datapath. It replaces combinational opcode decode with a sequenced fetch/decode/execute/memory/writeback controller.
- Holds the instruction register.
- Distinguishes R-type add/mul by OPX.
- Stalls for a parametrised multiply latency and handshakes with data memory.
- Resolves branches and counts retired instructions.

---
 rtl/multicycle_ctrl_unit_if.sv | 52 +++++
 rtl/multicycle_ctrl_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_unit_if.sv
// multicycle_ctrl_unit_if: control/handshake bundle between the multi-cycle controller and
// its surroundings (fetch path, ALU compare, data memory, register file, PC logic).
//   master : controller side. It samples inst_in/inst_valid/mem_ready/branch_cond and drives
//            every control output.
//   slave  : datapath/environment side, with the directions reversed.
// Signals:
//   inst_in, inst_valid        instruction from the fetch path and its valid flag
//   mem_ready                  data memory finished the current access
//   branch_cond                ALU compare result (rA < rB) for blt
//   fetch_req                  controller is waiting for an instruction
//   inst_out                   instruction register
//   reg_write, mem_write, mem_read, ALU_Src, RegDst, mem_to_reg, alu_op
//                              datapath controls
//   pc_inc, pc_write           PC+4 and branch-target load strobes
//   illegal_op, inst_done      unsupported-opcode and retire strobes
//   busy, retired_cnt          activity flag and retired-instruction counter
interface multicycle_ctrl_unit_if #(
  parameter int unsigned INST_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic [INST_W-1:0] inst_in;
  logic              inst_valid;
  logic              mem_ready;
  logic              branch_cond;
  logic              fetch_req;
  logic [INST_W-1:0] inst_out;
  logic              reg_write;
  logic              mem_write;
  logic              mem_read;
  logic              ALU_Src;
  logic              RegDst;
  logic              mem_to_reg;
  logic [2:0]        alu_op;
  logic              pc_inc;
  logic              pc_write;
  logic              illegal_op;
  logic              inst_done;
  logic              busy;
  logic [CNT_W-1:0]  retired_cnt;

  modport master (
    input  inst_in, inst_valid, mem_ready, branch_cond,
    output fetch_req, inst_out, reg_write, mem_write, mem_read, ALU_Src, RegDst, mem_to_reg,
           alu_op, pc_inc, pc_write, illegal_op, inst_done, busy, retired_cnt
  );

  modport slave (
    output inst_in, inst_valid, mem_ready, branch_cond,
    input  fetch_req, inst_out, reg_write, mem_write, mem_read, ALU_Src, RegDst, mem_to_reg,
           alu_op, pc_inc, pc_write, illegal_op, inst_done, busy, retired_cnt
  );
endinterface

// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit: sequenced fetch/decode/execute/memory/writeback controller for the
// Nios II-subset datapath. It holds the instruction register, splits R-type add/mul by OPX,
// stalls EXEC for MUL_CYCLES on mul, waits on mem_ready for ldw/stw, resolves blt/br and
// counts retired instructions.
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous, active-high reset
//   bus    multicycle_ctrl_unit_if.master (instruction in, memory/branch inputs, controls out)
// Every output is a flop loaded with the value belonging to the state being entered, so each
// output is valid for the whole cycle its state is occupied.
module multicycle_ctrl_unit #(
  parameter int unsigned INST_W     = 32,
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  multicycle_ctrl_unit_if.master bus
);

  localparam logic [5:0] OpcOrhi  = 6'h34;
  localparam logic [5:0] OpcOri   = 6'h14;
  localparam logic [5:0] OpcAddi  = 6'h04;
  localparam logic [5:0] OpcLdw   = 6'h17;
  localparam logic [5:0] OpcStw   = 6'h15;
  localparam logic [5:0] OpcBlt   = 6'h16;
  localparam logic [5:0] OpcBr    = 6'h06;
  localparam logic [5:0] OpcRtype = 6'h3A;
  localparam logic [5:0] OpxAdd   = 6'h31;
  localparam logic [5:0] OpxMul   = 6'h27;

  localparam logic [2:0] AluAdd   = 3'd0;
  localparam logic [2:0] AluOr    = 3'd1;
  localparam logic [2:0] AluOrhi  = 3'd2;
  localparam logic [2:0] AluMul   = 3'd3;
  localparam logic [2:0] AluCmplt = 3'd4;

  // The mul counter is loaded with MUL_CYCLES-1 and EXEC is left when it reads zero.
  localparam int unsigned      MulCntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [MulCntW-1:0] MulLast = MulCntW'(MUL_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StTrap
  } state_e;

  typedef enum logic [3:0] {
    OpOrhi, OpOri, OpAddi, OpLdw, OpStw, OpBlt, OpBr, OpAdd, OpMul
  } op_e;

  state_e              state_q;
  op_e                 op_q;
  logic [MulCntW-1:0]  mul_cnt_q;
  logic [INST_W-1:0]   inst_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                fetch_req_q;
  logic                reg_write_q;
  logic                mem_write_q;
  logic                mem_read_q;
  logic                alu_src_q;
  logic                reg_dst_q;
  logic                mem_to_reg_q;
  logic [2:0]          alu_op_q;
  logic                pc_inc_q;
  logic                pc_write_q;
  logic                illegal_op_q;
  logic                inst_done_q;
  logic                busy_q;

  // Decode of the held instruction, used on the edge that leaves DECODE.
  logic [5:0] opcode;
  logic [5:0] opx;
  logic       dec_legal;
  op_e        dec_op;

  assign opcode = inst_q[5:0];
  assign opx    = inst_q[16:11];

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = OpAdd;
    case (opcode)
      OpcOrhi: dec_op = OpOrhi;
      OpcOri:  dec_op = OpOri;
      OpcAddi: dec_op = OpAddi;
      OpcLdw:  dec_op = OpLdw;
      OpcStw:  dec_op = OpStw;
      OpcBlt:  dec_op = OpBlt;
      OpcBr:   dec_op = OpBr;
      OpcRtype: begin
        if (opx == OpxAdd) begin
          dec_op = OpAdd;
        end else if (opx == OpxMul) begin
          dec_op = OpMul;
        end else begin
          dec_legal = 1'b0;
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  function automatic logic [2:0] exec_alu_op(input op_e op);
    case (op)
      OpOrhi:  return AluOrhi;
      OpOri:   return AluOr;
      OpMul:   return AluMul;
      OpBlt:   return AluCmplt;
      default: return AluAdd;
    endcase
  endfunction

  function automatic logic exec_alu_src(input op_e op);
    return (op == OpOrhi) || (op == OpOri) || (op == OpAddi) || (op == OpLdw) || (op == OpStw);
  endfunction

  function automatic logic exec_reg_dst(input op_e op);
    return (op == OpAdd) || (op == OpMul);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= OpAdd;
      mul_cnt_q    <= '0;
      inst_q       <= '0;
      cnt_q        <= '0;
      fetch_req_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_op_q     <= AluAdd;
      pc_inc_q     <= 1'b0;
      pc_write_q   <= 1'b0;
      illegal_op_q <= 1'b0;
      inst_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Every output defaults low; each branch raises what its target state needs.
      fetch_req_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_op_q     <= AluAdd;
      pc_inc_q     <= 1'b0;
      pc_write_q   <= 1'b0;
      illegal_op_q <= 1'b0;
      inst_done_q  <= 1'b0;
      busy_q       <= 1'b0;

      unique case (state_q)
        StIdle: begin
          state_q     <= StFetch;
          fetch_req_q <= 1'b1;
        end

        StFetch: begin
          if (bus.inst_valid) begin
            inst_q   <= bus.inst_in;
            state_q  <= StDecode;
            pc_inc_q <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            fetch_req_q <= 1'b1;
          end
        end

        StDecode: begin
          busy_q <= 1'b1;
          if (dec_legal) begin
            op_q      <= dec_op;
            mul_cnt_q <= MulLast;
            state_q   <= StExec;
            alu_op_q  <= exec_alu_op(dec_op);
            alu_src_q <= exec_alu_src(dec_op);
            reg_dst_q <= exec_reg_dst(dec_op);
          end else begin
            state_q      <= StTrap;
            illegal_op_q <= 1'b1;
          end
        end

        StExec: begin
          if ((op_q == OpMul) && (mul_cnt_q != '0)) begin
            // Multiply still in flight: hold the EXEC controls.
            mul_cnt_q <= mul_cnt_q - MulCntW'(1);
            busy_q    <= 1'b1;
            alu_op_q  <= AluMul;
            reg_dst_q <= 1'b1;
          end else if ((op_q == OpLdw) || (op_q == OpStw)) begin
            state_q     <= StMem;
            busy_q      <= 1'b1;
            mem_read_q  <= (op_q == OpLdw);
            mem_write_q <= (op_q == OpStw);
            alu_src_q   <= 1'b1;
          end else if ((op_q == OpBlt) || (op_q == OpBr)) begin
            // Branches retire straight away; the target load lands in the first FETCH cycle.
            state_q     <= StFetch;
            fetch_req_q <= 1'b1;
            inst_done_q <= 1'b1;
            cnt_q       <= cnt_q + CNT_W'(1);
            pc_write_q  <= (op_q == OpBr) || bus.branch_cond;
          end else begin
            state_q     <= StWb;
            busy_q      <= 1'b1;
            reg_write_q <= 1'b1;
            alu_src_q   <= exec_alu_src(op_q);
            reg_dst_q   <= exec_reg_dst(op_q);
          end
        end

        StMem: begin
          if (!bus.mem_ready) begin
            busy_q      <= 1'b1;
            mem_read_q  <= (op_q == OpLdw);
            mem_write_q <= (op_q == OpStw);
            alu_src_q   <= 1'b1;
          end else if (op_q == OpLdw) begin
            state_q      <= StWb;
            busy_q       <= 1'b1;
            reg_write_q  <= 1'b1;
            mem_to_reg_q <= 1'b1;
            alu_src_q    <= 1'b1;
          end else begin
            state_q     <= StFetch;
            fetch_req_q <= 1'b1;
            inst_done_q <= 1'b1;
            cnt_q       <= cnt_q + CNT_W'(1);
          end
        end

        StWb: begin
          state_q     <= StFetch;
          fetch_req_q <= 1'b1;
          inst_done_q <= 1'b1;
          cnt_q       <= cnt_q + CNT_W'(1);
        end

        StTrap: begin
          // Illegal instructions are dropped without retiring.
          state_q     <= StFetch;
          fetch_req_q <= 1'b1;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.fetch_req   = fetch_req_q;
  assign bus.inst_out    = inst_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.ALU_Src     = alu_src_q;
  assign bus.RegDst      = reg_dst_q;
  assign bus.mem_to_reg  = mem_to_reg_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.pc_inc      = pc_inc_q;
  assign bus.pc_write    = pc_write_q;
  assign bus.illegal_op  = illegal_op_q;
  assign bus.inst_done   = inst_done_q;
  assign bus.busy        = busy_q;
  assign bus.retired_cnt = cnt_q;

endmodule
